// File: rtl/cla_pipe_adder_pkg.sv
// Shared configuration for the pipelined carry-lookahead adder: default group size
// and helpers that derive and validate the per-stage segment width.
package cla_pipe_adder_pkg;

    localparam int CLA_BLOCK_DEFAULT = 4;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int block, input int stages);
        return (stages > 0) && (block > 0) && ((width % (stages * block)) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit combinational carry-lookahead group: per-bit sums from cin plus the
// group propagate/generate pair used by the segment-level lookahead.
module cla_block
    import cla_pipe_adder_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK_DEFAULT
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             p,
    output logic             g
);

    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Group P/G deliberately never reads cin, so the segment lookahead has no loop.
    always_comb begin : group_pg
        // NOTE: blocking assignments in always_comb let the accumulator be re-read
        // within the same evaluation; every output gets a value before any branch.
        g = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            g = gen[i] | (prop[i] & g);
        end
        p = &prop;
    end

    always_comb begin : bit_sums
        logic gacc;
        logic pacc;
        gacc = 1'b0;
        pacc = 1'b1;
        sum  = '0;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = prop[i] ^ (gacc | (pacc & cin));
            gacc   = gen[i] | (prop[i] & gacc);
            pacc   = pacc & prop[i];
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage,
// LSB segment first, with a valid/ready stream interface and global stall.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = CLA_BLOCK_DEFAULT,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_W = seg_width(WIDTH, STAGES);
    localparam int NB    = SEG_W / BLOCK;
    localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_n;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_n [STAGES];
    logic [WIDTH-1:0]  opa_q [NREG];
    logic [WIDTH-1:0]  opb_q [NREG];
    logic [WIDTH-1:0]  opa_n [NREG];
    logic [WIDTH-1:0]  opb_n [NREG];
    logic              ovf_q;
    logic              ovf_n;
    logic              stall;

    assign stall     = v_q[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operands arrive pre-shifted so the current segment always sits in the low bits.
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic [NB-1:0]    bp;
        logic [NB-1:0]    bg;
        logic [NB-1:0]    bc;
        logic [SEG_W-1:0] seg_sum;
        logic             seg_cout;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = sub ? ~b : b;
            assign c_in = sub | cin;
            assign s_in = '0;
        end else begin : g_next
            assign a_in = opa_q[k-1];
            assign b_in = opb_q[k-1];
            assign c_in = c_q[k-1];
            assign s_in = sum_q[k-1];
        end

        for (genvar j = 0; j < NB; j++) begin : g_blk
            cla_block #(.BLOCK(BLOCK)) u_blk (
                .a   (a_in[j*BLOCK +: BLOCK]),
                .b   (b_in[j*BLOCK +: BLOCK]),
                .cin (bc[j]),
                .sum (seg_sum[j*BLOCK +: BLOCK]),
                .p   (bp[j]),
                .g   (bg[j])
            );
        end

        // Second-level lookahead: each group carry is formed directly from c_in.
        always_comb begin : group_carries
            logic gacc;
            logic pacc;
            gacc = 1'b0;
            pacc = 1'b1;
            bc   = '0;
            for (int j = 0; j < NB; j++) begin
                bc[j] = gacc | (pacc & c_in);
                gacc  = bg[j] | (bp[j] & gacc);
                pacc  = pacc & bp[j];
            end
            seg_cout = gacc | (pacc & c_in);
        end

        assign c_n[k]   = seg_cout;
        assign sum_n[k] = (s_in >> SEG_W) | (WIDTH'(seg_sum) << (WIDTH - SEG_W));

        if (k < STAGES - 1) begin : g_fwd
            assign opa_n[k] = a_in >> SEG_W;
            assign opb_n[k] = b_in >> SEG_W;
        end else begin : g_last
            assign ovf_n = (a_in[SEG_W-1] == b_in[SEG_W-1]) &&
                           (seg_sum[SEG_W-1] != a_in[SEG_W-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset alongside the valid bits so the
            // outputs read as zero after reset instead of X.
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
            end
            for (int k = 0; k < NREG; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (!stall) begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, independent of statement order.
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            c_q   <= c_n;
            ovf_q <= ovf_n;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_n[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                opa_q[k] <= opa_n[k];
                opb_q[k] <= opb_n[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and light random stimulus for cla_pipe_adder at WIDTH=16, BLOCK=4, STAGES=2.
module tb_cla_pipe_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           id;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int           passed = 0;
    int           total = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    bit           stall_prev = 1'b0;
    logic [W+1:0] snap;
    exp_t         q[$];
    vec_t         vecs[10];
    vec_t         idle;
    exp_t         idle_e;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic exp_t to_exp(input vec_t v, input int id);
        exp_t e;
        e.s = v.s; e.c = v.c; e.v = v.v; e.id = id; e.acc_cyc = 0;
        return e;
    endfunction

    function automatic exp_t model(input vec_t v, input int id);
        exp_t         e;
        logic [W-1:0] bp;
        logic [W:0]   r;
        bp = v.sub ? ~v.b : v.b;
        r  = {1'b0, v.a} + {1'b0, bp} + (W+1)'(v.sub ? 1'b1 : v.cin);
        e.s = r[W-1:0];
        e.c = r[W];
        e.v = (v.a[W-1] == bp[W-1]) && (r[W-1] != v.a[W-1]);
        e.id = id;
        e.acc_cyc = 0;
        return e;
    endfunction

    // One cycle: drive at the falling edge, then observe what the next rising edge will do.
    task automatic step(input logic iv, input vec_t v, input exp_t ex, input logic ordy,
                        input bit lat, output bit accepted);
        exp_t e;
        @(negedge clk);
        in_valid = iv; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = ordy;
        #1;
        if (out_valid && !out_ready) begin
            stall_cnt++;
            check("stall_in_ready", 64'(in_ready), 64'(0));
            if (stall_prev) check("stall_hold", 64'({sum, cout, ovf}), 64'(snap));
            stall_prev = 1'b1;
            snap = {sum, cout, ovf};
        end else begin
            stall_prev = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("out_with_empty_queue", 64'(out_valid), 64'(0));
            end else begin
                e = q.pop_front();
                check($sformatf("result_%0d", e.id), 64'({sum, cout, ovf}), 64'({e.s, e.c, e.v}));
                if (lat) check($sformatf("latency_%0d", e.id), 64'(cyc - e.acc_cyc), 64'(2));
            end
        end
        accepted = iv && in_ready;
        if (accepted) begin
            e = ex;
            e.acc_cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain(input bit lat);
        int n;
        bit acc;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1'b0, idle, idle_e, 1'b1, lat, acc);
            n++;
        end
        check("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        bit acc;
        int idx;
        int n;
        vec_t rv;

        vecs[0] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[1] = '{16'hFFF6, 16'hFFFC, 1'b1, 1'b0, 16'hFFF3, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFE, 16'h7FF1, 1'b1, 1'b0, 16'hFFF0, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
        idle    = '{default: '0};
        idle_e  = '{default: 0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_outputs", 64'({sum, cout, ovf}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Back-to-back table vectors, one per cycle, with latency checked per result.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i], to_exp(vecs[i], i), 1'b1, 1'b1, acc);
            check($sformatf("accept_%0d", i), 64'(acc), 64'(1));
        end
        drain(1'b1);

        // Backpressure: out_ready low for the first five cycles, stalling three of them.
        idx = 0; n = 0; stall_cnt = 0;
        while ((idx < 4 || q.size() != 0) && n < 40) begin
            step(idx < 4, vecs[idx], to_exp(vecs[idx], 20 + idx), n >= 5, 1'b0, acc);
            if (acc) idx++;
            n++;
        end
        check("bp_all_accepted", 64'(idx), 64'(4));
        check("bp_queue_empty", 64'(q.size()), 64'(0));
        check("bp_stall_cycles", 64'(stall_cnt), 64'(3));

        // Reset with two beats in flight discards both.
        step(1'b1, vecs[6], to_exp(vecs[6], 30), 1'b1, 1'b0, acc);
        step(1'b1, vecs[7], to_exp(vecs[7], 31), 1'b1, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({sum, cout, ovf}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        q.delete();
        stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, idle, idle_e, 1'b1, 1'b0, acc);
            check($sformatf("post_rst_quiet_%0d", i), 64'(out_valid), 64'(0));
        end

        // Random traffic with random in_valid/out_ready against the arithmetic model.
        for (int i = 0; i < 80; i++) begin
            rv.a = W'($urandom); rv.b = W'($urandom);
            rv.cin = 1'($urandom_range(0, 1)); rv.sub = 1'($urandom_range(0, 1));
            rv.s = '0; rv.c = 1'b0; rv.v = 1'b0;
            step($urandom_range(0, 3) != 0, rv, model(rv, 100 + i),
                 $urandom_range(0, 3) != 0, 1'b0, acc);
        end
        drain(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
